branch_target_predictor: RTL



---
 rtl/bp_pkg.sv | 16 +
 rtl/bp_sat_ctr.sv | 23 ++
 rtl/branch_target_predictor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction blocks.
package bp_pkg;

  // 2-bit saturating direction counter; MSB set means "predict taken".
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  localparam int   INSTR_BYTES = 4;
  localparam ctr_t CTR_ALLOC   = WEAK_T;
  localparam ctr_t CTR_RESET   = WEAK_NT;

endpackage : bp_pkg

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);

  // Step toward taken or not-taken, holding at either end.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ctr_o = ctr_i;
    unique case (ctr_i)
      STRONG_NT: ctr_o = taken_i ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   ctr_o = taken_i ? WEAK_T   : STRONG_NT;
      WEAK_T:    ctr_o = taken_i ? STRONG_T : WEAK_NT;
      STRONG_T:  ctr_o = taken_i ? STRONG_T : WEAK_T;
      default:   ctr_o = ctr_i;
    endcase
  end

endmodule : bp_sat_ctr

// File: rtl/branch_target_predictor.sv
// Next-PC unit: direct-mapped BTB with 2-bit direction counters, trained
// from execute, with a registered redirect and saturating mispredict count.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  output logic [WIDTH-1:0] next_pc,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [WIDTH-1:0] upd_offset,
  input  logic             upd_taken,
  input  logic             upd_pred_taken,
  input  logic [WIDTH-1:0] upd_pred_target,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

  // BTB storage
  logic [ENTRIES-1:0] valid_q;
  ctr_t               ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [WIDTH-1:0]   target_q [ENTRIES];

  // Fetch-side lookup
  logic [IDX-1:0]   fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;

  assign fetch_idx   = fetch_pc[IDX+1:2];
  assign fetch_tag   = fetch_pc[WIDTH-1:IDX+2];
  assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_target = target_q[fetch_idx];
  assign pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
  assign next_pc     = pred_taken ? pred_target : fetch_pc + STEP;

  // Execute-side resolution
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [WIDTH-1:0] calc_target;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] actual_next;
  logic [WIDTH-1:0] pred_next;
  logic             mispredict;
  ctr_t             ctr_trained;

  assign upd_idx     = upd_pc[IDX+1:2];
  assign upd_tag     = upd_pc[WIDTH-1:IDX+2];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign calc_target = upd_pc + upd_offset;
  assign seq_pc      = upd_pc + STEP;
  assign actual_next = upd_taken      ? calc_target     : seq_pc;
  assign pred_next   = upd_pred_taken ? upd_pred_target : seq_pc;
  assign mispredict  = (actual_next != pred_next);

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (ctr_q[upd_idx]),
    .taken_i (upd_taken),
    .ctr_o   (ctr_trained)
  );

  // Valid bits and direction counters: train on hit, allocate on taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (upd_valid) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, regardless of block order.
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_trained;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Tags and targets: written on hit or allocation, gated by valid_q when read.
  // NOTE: this array has no reset; valid_q masks its contents until written, so it can map to RAM.
  always_ff @(posedge clk) begin
    if (upd_valid && (upd_hit || upd_taken)) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= calc_target;
    end
  end

  // Redirect and statistics
  logic             redirect_valid_d, redirect_valid_q;
  logic [WIDTH-1:0] redirect_pc_d,    redirect_pc_q;
  logic [CNT_W-1:0] mp_cnt_d,         mp_cnt_q;

  // Next-state for the redirect pulse, held redirect PC and saturating count.
  always_comb begin
    redirect_valid_d = upd_valid && mispredict;
    redirect_pc_d    = redirect_pc_q;
    mp_cnt_d         = mp_cnt_q;
    if (upd_valid && mispredict) begin
      redirect_pc_d = actual_next;
      if (mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 1'b1;
    end
  end

  // Redirect and count registers; reset drops any pending redirect at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mp_cnt_q         <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mp_cnt_q         <= mp_cnt_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = mp_cnt_q;

endmodule : branch_target_predictor
